// File: rtl/sge_serial_pkg.sv
// Shared definitions for the bit-serial signed greater-or-equal comparator.
// Holds the FSM encoding and the MSB-time GE decision table.
package sge_serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // GE truth table indexed by {b, a, d}: rows (0,0,0) (0,1,0) (0,1,1) (1,1,0) as (a,b,d)
  localparam logic [7:0] GE_TABLE = 8'h71;

  function automatic logic ge_decide(input logic a, input logic b, input logic d);
    logic [2:0] idx;
    idx = {b, a, d};
    return GE_TABLE[idx];
  endfunction

endpackage

// File: rtl/sge_serial_sub_slice.sv
// Single combinational full-adder slice used for the serial A + ~B + 1 subtraction.
module serial_sub_slice (
  input  logic a,
  input  logic bn,
  input  logic c,
  output logic d,
  output logic c_out
);

  always_comb begin
    d     = a ^ bn ^ c;
    c_out = (a & bn) | (a & c) | (bn & c);
  end

endmodule

// File: rtl/sge_serial.sv
// Bit-serial signed A >= B / A == B comparator, operands LSB-first.
// One adder slice plus registered carry, zero flag and bit counter.
module sge_serial
  import sge_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic START,
  input  logic IN_VALID,
  input  logic I0,
  input  logic I1,
  output logic BUSY,
  output logic VALID,
  output logic O,
  output logic EQ
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             o_q, o_d;
  logic             eq_q, eq_d;

  logic             accept;
  logic             carry_in;
  logic             zero_in;
  logic [CNT_W-1:0] bit_idx;
  logic             diff;
  logic             carry_out;

  serial_sub_slice u_slice (
    .a     (I0),
    .bn    (~I1),
    .c     (carry_in),
    .d     (diff),
    .c_out (carry_out)
  );

  // START always restarts the operation, whether idle or mid-comparison
  always_comb begin
    accept   = START | ((state_q == ST_SHIFT) & IN_VALID);
    carry_in = START ? 1'b1 : carry_q;
    zero_in  = START ? 1'b1 : zero_q;
    bit_idx  = START ? '0 : cnt_q;
  end

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    o_d     = o_q;
    eq_d    = eq_q;

    if (accept) begin
      carry_d = carry_out;
      zero_d  = zero_in & ~diff;
      cnt_d   = bit_idx + CNT_W'(1);
      state_d = ST_SHIFT;
      if (bit_idx == CNT_W'(WIDTH - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        valid_d = 1'b1;
        o_d     = ge_decide(I0, I1, diff);
        eq_d    = zero_in & ~diff;
      end
    end

    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      carry_q <= 1'b1;
      zero_q  <= 1'b1;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      o_q     <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      o_q     <= o_d;
      eq_q    <= eq_d;
    end
  end

  assign BUSY  = busy_q;
  assign VALID = valid_q;
  assign O     = o_q;
  assign EQ    = eq_q;

endmodule

// File: doc/sge_serial.md
Name: sge_serial

Overview:
- Bit-serial signed greater-or-equal comparator for WIDTH-bit two's-complement operands.
- Operands arrive LSB-first, one bit of each per accepted cycle.
- Computes I0 - I1 with a single registered carry and a registered overflow/sign decision, so only one full-adder slice is used regardless of WIDTH.
- Sits behind serial links and shift-register front ends where a parallel SGE would cost a WIDTH-bit carry chain.

Parameters:
- WIDTH, 4, operand width in bits including sign; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  asynchronous active-low reset.
- START  input  1  begins a new comparison; the bits on I0/I1 this cycle are bit 0 (LSB).
- IN_VALID  input  1  qualifies I0/I1 on cycles after START; ignored in the START cycle, where the bit is always accepted.
- I0  input  1  serial operand A bit.
- I1  input  1  serial operand B bit.
- BUSY  output  1  comparison in progress; more bits are expected.
- VALID  output  1  one-cycle pulse; O and EQ are newly updated.
- O  output  1  registered result, 1 when A >= B (signed).
- EQ  output  1  registered result, 1 when A == B.

Behaviour:
- Reset (RESETN low, asynchronous): state=IDLE, BUSY=0, VALID=0, O=0, EQ=0, carry=1, bit counter=0, zero flag=1.
- Arithmetic per accepted bit k (A=I0, B=I1, Bn=~I1):
  - d = A ^ Bn ^ c
  - c' = maj(A, Bn, c), with c initialised to 1 at START (subtract = add inverted plus one).
  - zero' = zero & ~d.
- At the MSB (k = WIDTH-1), with a = A bit, b = B bit, d = difference MSB:
  - GE = 1 for (a,b,d) in {(0,0,0), (0,1,0), (0,1,1), (1,1,0)}; GE = 0 otherwise.
  - Equivalently GE = ~(d ^ V), where V = (a^b) & (a^d).
  - EQ = zero & ~d.
- States:
  - IDLE: BUSY=0. START moves to SHIFT, accepts bit 0 and loads counter=1. With WIDTH=2 the next accepted bit is already the MSB.
  - SHIFT: BUSY=1. Each IN_VALID=1 cycle accepts one bit and increments the counter. IN_VALID=0 stalls; no state changes. Accepting bit WIDTH-1 moves to IDLE.
  - DONE is not a separate state. The cycle after the MSB is accepted, VALID=1 and O/EQ hold the new values.
- Latency: VALID rises exactly one cycle after the MSB-accepting edge. With no stalls this is WIDTH cycles after the START cycle.
- O and EQ hold their last value until the next completed comparison. VALID is high for exactly one cycle per completed comparison.
- START while BUSY aborts the current comparison:
  - carry, zero and counter reinitialise and that cycle's bits are bit 0.
  - No VALID is produced for the aborted comparison; O/EQ are unchanged.
- START in the same cycle VALID is high is legal and back-to-back. This gives a throughput of one result per WIDTH cycles.
- IN_VALID with START=0 in IDLE: bits are ignored.
- Reset mid-operation: return to reset values immediately, with no VALID pulse. After RESETN deasserts, the first START begins cleanly.
- Counter width is clog2(WIDTH). The counter never wraps during a comparison because it reloads on every START.

Decomposition:
- Shared package:
  - state encoding (IDLE, SHIFT);
  - the GE decision function of (a, b, d) as a named constant truth table (8-bit, 0x71 with d as LSB index, a next, b top).
- One sub-module, serial_sub_slice: a combinational full-adder slice (inputs A, Bn, c; outputs d, c'). The top owns the carry register, zero flag, counter, FSM and result registers.

Test Plan (WIDTH=4, bits sent LSB-first, no stalls unless stated):
- A=3 (0011), B=-2 (1110): START plus 4 bits -> VALID pulses 4 cycles after START; O=1, EQ=0.
- A=-8 (1000), B=7 (0111), the overflow case -> O=0, EQ=0. Then A=7, B=-8 -> O=1.
- A=5, B=5 -> O=1, EQ=1. Then A=-1, B=0 -> O=0, EQ=0, and the previous values are held until VALID.
- A=2, B=1 with IN_VALID low for 3 cycles after bit 1 -> VALID arrives 7 cycles after START, O=1. BUSY stays 1 through the stall.
- Abort: start A=-3 vs B=4, issue a new START at bit 2 with A=6, B=6 -> exactly one VALID, for the second operation, with O=1, EQ=1.
- Reset: RESETN low at bit 2 of any comparison -> BUSY, VALID, O and EQ all read 0 asynchronously. A subsequent A=0, B=-1 comparison gives O=1.
